// File: rtl/ast_pkt_pkg.sv
// ast_pkt_pkg: shared constants, FSM state type and length helpers for the
// Avalon-ST packet generator.
//   MIN_BYTES / MAX_BYTES : legal command length range (inclusive)
//   state_e               : generator FSM states
//   beats_of(len, bpw)    : number of bus beats needed for len bytes
//   empty_of(len, bpw)    : unused byte lanes in the final beat
package ast_pkt_pkg;

  localparam int MIN_BYTES = 60;
  localparam int MAX_BYTES = 1514;

  typedef enum logic [1:0] {
    IDLE_S,
    SEND_S,
    GAP_S
  } state_e;

  function automatic int beats_of(input int len, input int bpw);
    return (len + bpw - 1) / bpw;
  endfunction

  function automatic int empty_of(input int len, input int bpw);
    return bpw * beats_of(len, bpw) - len;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// avalon_st_if: Avalon-ST bundle with channel and empty signalling.
//   data, valid, startofpacket, endofpacket, empty, channel : source -> sink
//   ready                                                   : sink -> source
// readyLatency is 0: a beat transfers on any cycle where valid & ready.
interface avalon_st_if #(
  parameter int DWIDTH        = 64,
  parameter int CHANNEL_WIDTH = 1,
  parameter int EMPTY_WIDTH   = (DWIDTH / 8 > 1) ? $clog2(DWIDTH / 8) : 1
);

  logic [DWIDTH-1:0]        data;
  logic                     valid;
  logic                     startofpacket;
  logic                     endofpacket;
  logic [EMPTY_WIDTH-1:0]   empty;
  logic [CHANNEL_WIDTH-1:0] channel;
  logic                     ready;

  modport src (
    output data, valid, startofpacket, endofpacket, empty, channel,
    input  ready
  );

  modport snk (
    input  data, valid, startofpacket, endofpacket, empty, channel,
    output ready
  );

endinterface

// File: rtl/ast_pattern_word.sv
// ast_pattern_word: combinational byte-pattern generator for one bus beat.
//   seed_i   : value of packet byte 0
//   offset_i : packet byte index of this beat's first byte, modulo 256
//   word_o   : beat data; byte b = seed + offset + b (mod 256), with byte 0
//              in the most significant lane (first-symbol-high)
module ast_pattern_word #(
  parameter int AST_DWIDTH = 64
) (
  input  logic [7:0]            seed_i,
  input  logic [7:0]            offset_i,
  output logic [AST_DWIDTH-1:0] word_o
);

  localparam int BPW = AST_DWIDTH / 8;

  logic [7:0] base;

  assign base = seed_i + offset_i;

  always_comb begin
    word_o = '0;
    for (int b = 0; b < BPW; b++) begin
      word_o[AST_DWIDTH-1-8*b -: 8] = base + 8'(b);
    end
  end

endmodule

// File: rtl/ast_packet_gen.sv
// ast_packet_gen: Avalon-ST packet source. One command (length, channel,
// seed) produces one sop/eop-framed packet whose byte i is (seed + i) mod 256.
//   clk_i, arst_n_i          : clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o  : command handshake (accepted only in IDLE)
//   cmd_len_i                : packet length in bytes (60..1514 legal)
//   cmd_channel_i            : channel driven for the whole packet
//   cmd_seed_i               : value of packet byte 0
//   src_if                   : Avalon-ST source, readyLatency 0
//   busy_o                   : high outside IDLE
//   pkt_cnt_o                : packets whose eop handshook (saturating)
//   err_cnt_o                : commands rejected for illegal length (saturating)
module ast_packet_gen
  import ast_pkt_pkg::*;
#(
  parameter int AST_DWIDTH    = 64,
  parameter int CHANNEL_WIDTH = 1,
  parameter int LEN_WIDTH     = 11,
  parameter int GAP_CYCLES    = 0
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [LEN_WIDTH-1:0]     cmd_len_i,
  input  logic [CHANNEL_WIDTH-1:0] cmd_channel_i,
  input  logic [7:0]               cmd_seed_i,
  avalon_st_if.src                 src_if,
  output logic                     busy_o,
  output logic [15:0]              pkt_cnt_o,
  output logic [15:0]              err_cnt_o
);

  localparam int         BPW     = AST_DWIDTH / 8;
  localparam int         EMPTY_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int         GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [7:0] BPW_B   = 8'(BPW);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_e                   state_q, state_d;
  logic                     rdy_q;
  logic [GAP_W-1:0]         gap_q;
  logic [15:0]              pkt_cnt_q, err_cnt_q;

  // Per-packet context latched at command accept.
  logic [7:0]               seed_q;
  logic [7:0]               off_q;          // byte offset of current beat, mod 256
  logic [LEN_WIDTH-1:0]     beat_q;
  logic [LEN_WIDTH-1:0]     last_beat_q;
  logic [EMPTY_W-1:0]       empty_last_q;

  // Registered source outputs.
  logic                     vld_q, sop_q, eop_q;
  logic [EMPTY_W-1:0]       empty_q;
  logic [CHANNEL_WIDTH-1:0] chan_q;
  logic [AST_DWIDTH-1:0]    data_q;

  logic                     cmd_fire, len_ok, accept, reject;
  logic                     beat_fire, last_fire, gap_done;
  logic [LEN_WIDTH-1:0]     beats_cmd;
  logic [EMPTY_W-1:0]       empty_cmd;

  logic [7:0]               pat_seed, pat_off;
  logic [AST_DWIDTH-1:0]    pat_word, pat_mask;
  logic                     nxt_eop;
  logic [EMPTY_W-1:0]       nxt_empty;

  // rdy_q is only ever high in IDLE, so it doubles as the IDLE accept gate.
  assign cmd_fire  = cmd_valid_i & rdy_q;
  assign len_ok    = (int'(cmd_len_i) >= MIN_BYTES) && (int'(cmd_len_i) <= MAX_BYTES);
  assign accept    = cmd_fire & len_ok;
  assign reject    = cmd_fire & ~len_ok;
  assign beat_fire = vld_q & src_if.ready;
  assign last_fire = beat_fire & eop_q;
  assign gap_done  = (gap_q == GAP_W'(GAP_CYCLES - 1));

  assign beats_cmd = LEN_WIDTH'(beats_of(int'(cmd_len_i), BPW));
  assign empty_cmd = EMPTY_W'(empty_of(int'(cmd_len_i), BPW));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_S:  if (accept)    state_d = SEND_S;
      SEND_S:  if (last_fire) state_d = (GAP_CYCLES > 0) ? GAP_S : IDLE_S;
      GAP_S:   if (gap_done)  state_d = IDLE_S;
      default:                state_d = IDLE_S;
    endcase
  end

  // Next beat to present: beat 0 of a new packet, or the successor of the
  // beat currently on the bus.
  always_comb begin
    pat_seed  = seed_q;
    pat_off   = off_q + BPW_B;
    nxt_eop   = ((beat_q + LEN_WIDTH'(1)) == last_beat_q);
    nxt_empty = nxt_eop ? empty_last_q : '0;
    if (accept) begin
      pat_seed  = cmd_seed_i;
      pat_off   = '0;
      nxt_eop   = (beats_cmd == LEN_WIDTH'(1));
      nxt_empty = nxt_eop ? empty_cmd : '0;
    end
    // Zero the unused low lanes of the eop beat.
    pat_mask = {AST_DWIDTH{1'b1}} << {nxt_empty, 3'b000};
  end

  ast_pattern_word #(
    .AST_DWIDTH (AST_DWIDTH)
  ) u_pattern (
    .seed_i   (pat_seed),
    .offset_i (pat_off),
    .word_o   (pat_word)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q   <= IDLE_S;
      rdy_q     <= 1'b0;
      gap_q     <= '0;
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == IDLE_S);
      if (last_fire) begin
        gap_q <= '0;
      end else if (state_q == GAP_S) begin
        gap_q <= gap_q + GAP_W'(1);
      end
      if (last_fire) pkt_cnt_q <= sat_inc16(pkt_cnt_q);
      if (reject)    err_cnt_q <= sat_inc16(err_cnt_q);
    end
  end

  // Output stage: registered beat, advanced only on handshake so everything
  // holds while ready is low.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      vld_q        <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      empty_q      <= '0;
      chan_q       <= '0;
      data_q       <= '0;
      seed_q       <= '0;
      off_q        <= '0;
      beat_q       <= '0;
      last_beat_q  <= '0;
      empty_last_q <= '0;
    end else if (accept) begin
      vld_q        <= 1'b1;
      sop_q        <= 1'b1;
      eop_q        <= nxt_eop;
      empty_q      <= nxt_empty;
      chan_q       <= cmd_channel_i;
      data_q       <= pat_word & pat_mask;
      seed_q       <= cmd_seed_i;
      off_q        <= '0;
      beat_q       <= '0;
      last_beat_q  <= beats_cmd - LEN_WIDTH'(1);
      empty_last_q <= empty_cmd;
    end else if (last_fire) begin
      vld_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      empty_q <= '0;
      chan_q  <= '0;
      data_q  <= '0;
    end else if (beat_fire) begin
      sop_q   <= 1'b0;
      eop_q   <= nxt_eop;
      empty_q <= nxt_empty;
      data_q  <= pat_word & pat_mask;
      off_q   <= off_q + BPW_B;
      beat_q  <= beat_q + LEN_WIDTH'(1);
    end
  end

  assign src_if.valid         = vld_q;
  assign src_if.startofpacket = sop_q;
  assign src_if.endofpacket   = eop_q;
  assign src_if.empty         = empty_q;
  assign src_if.channel       = chan_q;
  assign src_if.data          = data_q;

  assign cmd_ready_o = rdy_q;
  assign busy_o      = (state_q != IDLE_S);
  assign pkt_cnt_o   = pkt_cnt_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_ast_packet_gen.sv
// tb_ast_packet_gen: self-checking bench for ast_packet_gen (64-bit bus,
// 1-bit channel, no inter-packet gap). A reference model pushes the expected
// beats of each accepted command into a queue; a negedge monitor pops and
// compares every handshaken beat.
module tb_ast_packet_gen;

  localparam int DW  = 64;
  localparam int BPW = DW / 8;
  localparam int LW  = 11;

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    logic        ch;
  } beat_t;

  typedef struct {
    int          len;
    logic [7:0]  seed;
    logic        ch;
    int          rmode;      // 0: ready held high, 1: ready random
    int          exp_beats;  // 0 for an illegal length
    int          exp_empty;
    bit          chk_words;
    logic [63:0] first_w;
    logic [63:0] last_w;
  } vec_t;

  logic          clk;
  logic          arst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len;
  logic          cmd_ch;
  logic [7:0]    cmd_seed;
  logic          busy;
  logic [15:0]   pkt_cnt;
  logic [15:0]   err_cnt;

  avalon_st_if #(.DWIDTH(DW), .CHANNEL_WIDTH(1)) sif ();

  ast_packet_gen #(
    .AST_DWIDTH    (DW),
    .CHANNEL_WIDTH (1),
    .LEN_WIDTH     (LW),
    .GAP_CYCLES    (0)
  ) dut (
    .clk_i         (clk),
    .arst_n_i      (arst_n),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_len_i     (cmd_len),
    .cmd_channel_i (cmd_ch),
    .cmd_seed_i    (cmd_seed),
    .src_if        (sif),
    .busy_o        (busy),
    .pkt_cnt_o     (pkt_cnt),
    .err_cnt_o     (err_cnt)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  beat_t       exp_q[$];
  vec_t        tbl[6];
  int          ready_mode = 0;
  int          pkt_beats  = 0;
  int          valid_seen = 0;
  logic [63:0] first_data, last_data;
  logic [2:0]  last_empty;
  logic        stalled, prev_eop_fire;
  logic [63:0] held_data;
  logic [6:0]  held_ctl;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Ready driver: changes just after the rising edge so the DUT sees a
  // stable value at the next edge.
  initial begin
    sif.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      sif.ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Reference model: byte i of the packet is (seed + i) mod 256, first byte
  // in the top lane, lanes past the packet end are zero.
  task automatic push_pkt(input int len, input logic [7:0] seed, input logic ch);
    int nb;
    beat_t b;
    nb = (len + BPW - 1) / BPW;
    for (int k = 0; k < nb; k++) begin
      b.data = '0;
      for (int j = 0; j < BPW; j++) begin
        int i;
        i = k * BPW + j;
        if (i < len) b.data[63-8*j -: 8] = seed + 8'(i);
      end
      b.sop   = (k == 0);
      b.eop   = (k == nb - 1);
      b.empty = (k == nb - 1) ? 3'(nb * BPW - len) : 3'd0;
      b.ch    = ch;
      exp_q.push_back(b);
    end
  endtask

  // Called at a negedge; returns at a negedge after the handshake.
  task automatic send_cmd(input int len, input logic [7:0] seed, input logic ch);
    int n;
    n         = 0;
    cmd_len   = LW'(len);
    cmd_seed  = seed;
    cmd_ch    = ch;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", 64'd0, 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    if (len >= 60 && len <= 1514) push_pkt(len, seed, ch);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || sif.valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || busy || sif.valid) check("done_timeout", 64'd0, 64'd1);
  endtask

  // Monitor: scoreboard compare on every handshake, hold checks while
  // stalled, and sop-spacing check after each eop.
  always @(negedge clk) begin
    if (!arst_n) begin
      stalled       = 1'b0;
      prev_eop_fire = 1'b0;
    end else begin
      if (sif.valid) valid_seen++;
      if (stalled) begin
        check("hold_data", sif.data, held_data);
        check("hold_ctl",
              64'({sif.valid, sif.startofpacket, sif.endofpacket, sif.empty, sif.channel}),
              64'(held_ctl));
      end
      if (sif.valid && sif.ready) begin
        if (sif.startofpacket) begin
          check("sop_spacing", 64'(prev_eop_fire), 64'd0);
          pkt_beats  = 0;
          first_data = sif.data;
        end
        pkt_beats++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", sif.data, e.data);
          check("beat_ctl",
                64'({sif.startofpacket, sif.endofpacket, sif.empty, sif.channel}),
                64'({e.sop, e.eop, e.empty, e.ch}));
        end
        if (sif.endofpacket) begin
          last_data  = sif.data;
          last_empty = sif.empty;
        end
      end
      prev_eop_fire = sif.valid & sif.ready & sif.endofpacket;
      stalled       = sif.valid & ~sif.ready;
      held_data     = sif.data;
      held_ctl      = {sif.valid, sif.startofpacket, sif.endofpacket, sif.empty, sif.channel};
    end
  end

  initial begin
    int exp_pkt;
    int exp_err;
    int n;

    tbl[0] = '{60,   8'h00, 1'b1, 0, 8,   4, 1'b1, 64'h0001020304050607, 64'h38393A3B00000000};
    tbl[1] = '{64,   8'hFC, 1'b0, 0, 8,   0, 1'b1, 64'hFCFDFEFF00010203, 64'h3435363738393A3B};
    tbl[2] = '{1514, 8'h5A, 1'b1, 0, 190, 6, 1'b0, 64'h0, 64'h0};
    tbl[3] = '{59,   8'h10, 1'b1, 0, 0,   0, 1'b0, 64'h0, 64'h0};
    tbl[4] = '{1515, 8'h20, 1'b0, 0, 0,   0, 1'b0, 64'h0, 64'h0};
    tbl[5] = '{100,  8'h80, 1'b1, 1, 13,  4, 1'b0, 64'h0, 64'h0};

    arst_n    = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    cmd_ch    = 1'b0;
    cmd_seed  = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_valid",  64'(sif.valid), 64'd0);
    check("rst_sop",    64'(sif.startofpacket), 64'd0);
    check("rst_eop",    64'(sif.endofpacket), 64'd0);
    check("rst_empty",  64'(sif.empty), 64'd0);
    check("rst_chan",   64'(sif.channel), 64'd0);
    check("rst_data",   sif.data, 64'd0);
    check("rst_ready",  64'(cmd_ready), 64'd0);
    check("rst_busy",   64'(busy), 64'd0);
    check("rst_pktcnt", 64'(pkt_cnt), 64'd0);
    check("rst_errcnt", 64'(err_cnt), 64'd0);

    arst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(cmd_ready), 64'd1);

    exp_pkt = 0;
    exp_err = 0;
    for (int i = 0; i < 6; i++) begin
      ready_mode = tbl[i].rmode;
      valid_seen = 0;
      pkt_beats  = 0;
      send_cmd(tbl[i].len, tbl[i].seed, tbl[i].ch);
      wait_done(3000);
      ready_mode = 0;
      if (tbl[i].len >= 60 && tbl[i].len <= 1514) exp_pkt++;
      else exp_err++;
      check("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
      check("err_cnt", 64'(err_cnt), 64'(exp_err));
      if (tbl[i].exp_beats > 0) begin
        check("beat_count", 64'(pkt_beats), 64'(tbl[i].exp_beats));
        check("eop_empty",  64'(last_empty), 64'(tbl[i].exp_empty));
      end else begin
        check("no_valid_on_reject", 64'(valid_seen), 64'd0);
        check("ready_after_reject", 64'(cmd_ready), 64'd1);
      end
      if (tbl[i].chk_words) begin
        check("first_word", first_data, tbl[i].first_w);
        check("last_word",  last_data,  tbl[i].last_w);
      end
    end

    // Back-to-back commands: second sop must not follow eop directly.
    send_cmd(60, 8'h20, 1'b0);
    send_cmd(61, 8'h40, 1'b1);
    wait_done(3000);
    exp_pkt += 2;
    check("b2b_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
    check("b2b_empty",   64'(last_empty), 64'd3);

    // Reset in the middle of a 200-byte packet.
    send_cmd(200, 8'hA0, 1'b1);
    n = 0;
    while (pkt_beats < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_pkt_reached", 64'(pkt_beats >= 3), 64'd1);
    #1;
    arst_n = 1'b0;
    #1;
    check("arst_valid",  64'(sif.valid), 64'd0);
    check("arst_sop",    64'(sif.startofpacket), 64'd0);
    check("arst_eop",    64'(sif.endofpacket), 64'd0);
    check("arst_empty",  64'(sif.empty), 64'd0);
    check("arst_chan",   64'(sif.channel), 64'd0);
    check("arst_data",   sif.data, 64'd0);
    check("arst_ready",  64'(cmd_ready), 64'd0);
    check("arst_busy",   64'(busy), 64'd0);
    check("arst_pktcnt", 64'(pkt_cnt), 64'd0);
    exp_q.delete();
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    pkt_beats = 0;
    send_cmd(60, 8'h11, 1'b0);
    wait_done(3000);
    check("post_rst_pkt_cnt", 64'(pkt_cnt), 64'd1);
    check("post_rst_err_cnt", 64'(err_cnt), 64'd0);
    check("post_rst_beats",   64'(pkt_beats), 64'd8);
    check("post_rst_first",   first_data, 64'h1112131415161718);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
